// File: rtl/rr_output_arbiter_pkg.sv
// Shared types and helpers for the round-robin output arbiter.
package rr_output_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Wide enough for any supported W; the top truncates to its own width.
    localparam logic [63:0] DEFAULT_IDLE_VAL = '1;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick
    import rr_output_arbiter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]          req,
    input  logic [clog2(N)-1:0]   ptr,
    output logic [N-1:0]          pick,
    output logic                  found
);

    localparam int OW = clog2(N);

    logic [OW-1:0] idx;

    always_comb begin
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            idx = OW'((int'(ptr) + i) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_output_arbiter.sv
// Round-robin owner of a shared registered output with bounded tenure.
// Optional ARB_LOCK_EN adds a lock input that suppresses tenure preemption.
module rr_output_arbiter
    import rr_output_arbiter_pkg::*;
#(
    parameter int             N        = 4,
    parameter int             W        = 8,
    parameter int             MAX_HOLD = 15,
    parameter logic [W-1:0]   IDLE_VAL = W'(DEFAULT_IDLE_VAL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
`ifdef ARB_LOCK_EN
    input  logic                  lock,
`endif
    input  logic [N-1:0]          req,
    input  logic [N*W-1:0]        req_data,
    output logic [N-1:0]          gnt,
    output logic                  out_valid,
    output logic [W-1:0]          out_data,
    output logic [clog2(N)-1:0]   out_owner,
    output logic                  preempt
);

    localparam int           OW       = clog2(N);
    localparam logic [7:0]   HOLD_MAX = 8'(MAX_HOLD);

    arb_state_e     state_p1, state_d;
    logic [OW-1:0]  ptr_p1, ptr_d;
    logic [OW-1:0]  owner_d, pick_ptr, next_after_owner, pick_idx;
    logic [7:0]     hold_p1, hold_d;
    logic [N-1:0]   gnt_d, pick_req, pick;
    logic           found, preempt_d, preempt_ok;
    logic [W-1:0]   data_d;

`ifdef ARB_LOCK_EN
    assign preempt_ok = ~lock;
`else
    assign preempt_ok = 1'b1;
`endif

    assign next_after_owner = (out_owner == OW'(N - 1)) ? '0 : out_owner + 1'b1;
    assign out_valid        = |gnt;

    // While owned, search only the other requesters, starting just past the owner.
    always_comb begin
        if (state_p1 == OWN) begin
            pick_req = req & ~gnt;
            pick_ptr = next_after_owner;
        end else begin
            pick_req = req;
            pick_ptr = ptr_p1;
        end
    end

    rr_pick #(.N(N)) u_pick (
        .req   (pick_req),
        .ptr   (pick_ptr),
        .pick  (pick),
        .found (found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick[i]) pick_idx = OW'(i);
        end
    end

    always_comb begin
        state_d   = state_p1;
        ptr_d     = ptr_p1;
        owner_d   = out_owner;
        hold_d    = hold_p1;
        gnt_d     = gnt;
        preempt_d = 1'b0;
        case (state_p1)
            IDLE: begin
                if (found) begin
                    state_d = OWN;
                    gnt_d   = pick;
                    owner_d = pick_idx;
                    hold_d  = 8'd1;
                end
            end
            OWN: begin
                if (!(|(req & gnt))) begin
                    ptr_d = next_after_owner;
                    if (found) begin
                        gnt_d   = pick;
                        owner_d = pick_idx;
                        hold_d  = 8'd1;
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                        owner_d = '0;
                        hold_d  = 8'd0;
                    end
                end else if (hold_p1 >= HOLD_MAX && found && preempt_ok) begin
                    preempt_d = 1'b1;
                    ptr_d     = next_after_owner;
                    gnt_d     = pick;
                    owner_d   = pick_idx;
                    hold_d    = 8'd1;
                end else if (hold_p1 < HOLD_MAX) begin
                    hold_d = hold_p1 + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Data is captured from whichever requester owns the line after this edge.
    assign data_d = (|gnt_d) ? req_data[owner_d*W +: W] : IDLE_VAL;

    // ---- stage p1: registered grant, owner and shared output ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1  <= IDLE;
            ptr_p1    <= '0;
            hold_p1   <= 8'd0;
            gnt       <= '0;
            out_owner <= '0;
            out_data  <= IDLE_VAL;
            preempt   <= 1'b0;
        end else begin
            state_p1  <= state_d;
            ptr_p1    <= ptr_d;
            hold_p1   <= hold_d;
            gnt       <= gnt_d;
            out_owner <= owner_d;
            out_data  <= data_d;
            preempt   <= preempt_d;
        end
    end

endmodule
